// File: rtl/serial_negator_w_if.sv
// ============================================================================
// Module   : serial_negator_w_if
// Brief    : Serial bit stream and assembled-word bundle for serial_negator_w.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_negator_w_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_start;
  logic             in_bit;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_bit;
  logic             out_last;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             ovf;
  logic             frame_err;

  modport master (
    output in_valid, in_start, in_bit, mode,
    input  out_valid, out_bit, out_last, word_out, word_valid, ovf, frame_err
  );

  modport slave (
    input  in_valid, in_start, in_bit, mode,
    output out_valid, out_bit, out_last, word_out, word_valid, ovf, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/serial_negator_w.sv
// ============================================================================
// Module   : serial_negator_w
// Brief    : LSB-first bit-serial pass / invert / two's-complement negate with
//            per-word framing, parallel word assembly and overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_negator_w #(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  serial_negator_w_if.slave  bus
);

  localparam int              c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SEEK = 2'd1;
  localparam logic [1:0] c_FLIP = 2'd2;
  localparam logic [1:0] c_COPY = 2'd3;

  logic [1:0]       r_state, w_state_nxt, w_cur;
  logic [c_CW-1:0]  r_cnt, w_cnt_nxt, w_idx;
  logic             r_inv, w_inv_nxt, w_inv_cur;
  logic             w_start, w_acc, w_last;
  logic             w_out_bit, w_ovf, w_ferr;
  logic [WIDTH-1:0] r_shadow, w_shadow_nxt;

  logic             r_out_valid, r_out_bit, r_out_last;
  logic             r_word_valid, r_ovf, r_frame_err;
  logic [WIDTH-1:0] r_word_out;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_inv   <= w_inv_nxt;
    end
  end

  // Next-state logic; a start overrides whatever word is in flight
  always_comb begin
    w_start = bus.in_valid & bus.in_start;
    w_acc   = bus.in_valid & (bus.in_start | (r_state != c_IDLE));
    w_idx   = w_start ? '0 : r_cnt;
    w_last  = (w_idx == c_LAST);
    if (w_start) begin
      w_cur     = (bus.mode == 2'b01) ? c_SEEK : c_COPY;
      w_inv_cur = (bus.mode == 2'b10);
    end else begin
      w_cur     = r_state;
      w_inv_cur = r_inv;
    end

    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_inv_nxt   = r_inv;
    if (w_acc) begin
      w_inv_nxt = w_inv_cur;
      if (w_last) begin
        w_state_nxt = c_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = w_idx + c_CW'(1);
        case (w_cur)
          c_SEEK:  w_state_nxt = bus.in_bit ? c_FLIP : c_SEEK;
          default: w_state_nxt = w_cur;
        endcase
      end
    end
  end

  // Output logic
  always_comb begin
    case (w_cur)
      c_FLIP:  w_out_bit = ~bus.in_bit;
      c_COPY:  w_out_bit = bus.in_bit ^ w_inv_cur;
      default: w_out_bit = bus.in_bit;
    endcase
    // Still seeking at the MSB means every lower bit was zero
    w_ovf        = w_last & (w_cur == c_SEEK) & bus.in_bit;
    w_ferr       = w_start & (r_state != c_IDLE);
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[w_idx] = w_out_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow     <= '0;
      r_word_out   <= '0;
      r_out_valid  <= 1'b0;
      r_out_bit    <= 1'b0;
      r_out_last   <= 1'b0;
      r_word_valid <= 1'b0;
      r_ovf        <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_shadow <= w_shadow_nxt;
      end
      if (w_acc && w_last) begin
        r_word_out <= w_shadow_nxt;
      end
      r_out_valid  <= w_acc;
      r_out_bit    <= w_acc & w_out_bit;
      r_out_last   <= w_acc & w_last;
      r_word_valid <= w_acc & w_last;
      r_ovf        <= w_acc & w_ovf;
      r_frame_err  <= w_ferr;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_bit    = r_out_bit;
  assign bus.out_last   = r_out_last;
  assign bus.word_out   = r_word_out;
  assign bus.word_valid = r_word_valid;
  assign bus.ovf        = r_ovf;
  assign bus.frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_serial_negator_w.sv
// ============================================================================
// Module   : tb_serial_negator_w
// Brief    : Self-checking bench for serial_negator_w against a word-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_negator_w;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_negator_w_if #(.WIDTH(W)) bus ();
  serial_negator_w #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  bit           mon_bits[$];
  int           mon_vcyc[$];
  logic [W-1:0] mon_words[$];
  logic         mon_ovf[$];
  int           mon_ferr;
  int           mon_lastbad;

  always @(negedge clk) begin
    if (reset) begin
      if (bus.out_valid) begin
        mon_bits.push_back(bus.out_bit);
        mon_vcyc.push_back(cyc);
      end
      if (bus.out_last !== bus.word_valid) mon_lastbad++;
      if (bus.word_valid) begin
        mon_words.push_back(bus.word_out);
        mon_ovf.push_back(bus.ovf);
      end
      if (bus.frame_err) mon_ferr++;
    end
  end

  function automatic logic [W-1:0] model_res(input logic [W-1:0] v, input logic [1:0] m);
    case (m)
      2'b01:   return W'(0) - v;
      2'b10:   return ~v;
      default: return v;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] v, input logic [1:0] m);
    return (m == 2'b01) && (v == {1'b1, {(W-1){1'b0}}});
  endfunction

  task automatic clear_mon();
    mon_bits.delete(); mon_vcyc.delete(); mon_words.delete(); mon_ovf.delete();
    mon_ferr = 0; mon_lastbad = 0;
  endtask

  task automatic drive(input logic v, input logic s, input logic b, input logic [1:0] m);
    @(posedge clk); #1;
    bus.in_valid = v; bus.in_start = s; bus.in_bit = b; bus.mode = m;
  endtask

  // Gap cycles carry junk start/data/mode that must be ignored
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
  endtask

  task automatic send_word(input logic [W-1:0] v, input logic [1:0] m, input int gap);
    for (int i = 0; i < W; i++) begin
      drive(1'b1, i == 0, v[i], (i == 0) ? m : 2'($urandom));
      if (gap == 1) idle(1);
      else if (gap == 2) idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 0; bus.in_start = 0; bus.in_bit = 0; bus.mode = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.out_valid, bus.out_bit, bus.out_last, bus.word_out, bus.word_valid, bus.ovf, bus.frame_err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got wv=%b wo=%h ov=%b expected all zero", bus.word_valid, bus.word_out, bus.out_valid);
    end
    @(negedge clk); reset = 1'b1;
    clear_mon();
    // Valid bits without a start are ignored in IDLE
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'($urandom), 2'($urandom));
    idle(3);
    n_vec++;
    if (mon_bits.size() != 0 || mon_words.size() != 0) begin
      n_bad++; $display("FAIL idle_no_start: got %0d bits %0d words expected 0 0", mon_bits.size(), mon_words.size());
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] vals[6]  = '{8'h06, 8'h80, 8'h00, 8'h5A, 8'h5A, 8'h3C};
    logic [1:0]   modes[6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b11};
    logic [W-1:0] ser, exp;
    for (int t = 0; t < 6; t++) begin
      clear_mon();
      send_word(vals[t], modes[t], 0);
      idle(3);
      exp = model_res(vals[t], modes[t]);
      n_vec++;
      if (mon_words.size() != 1 || mon_bits.size() != W) begin
        n_bad++; $display("FAIL dir%0d_count: got %0d words %0d bits expected 1 %0d", t, mon_words.size(), mon_bits.size(), W);
      end else begin
        for (int k = 0; k < W; k++) ser[k] = mon_bits[k];
        n_vec++;
        if (mon_words[0] !== exp) begin
          n_bad++; $display("FAIL dir%0d_word: got %h expected %h", t, mon_words[0], exp);
        end
        n_vec++;
        if (ser !== exp) begin
          n_bad++; $display("FAIL dir%0d_serial: got %h expected %h", t, ser, exp);
        end
        n_vec++;
        if (mon_ovf[0] !== model_ovf(vals[t], modes[t])) begin
          n_bad++; $display("FAIL dir%0d_ovf: got %b expected %b", t, mon_ovf[0], model_ovf(vals[t], modes[t]));
        end
      end
      n_vec++;
      if (mon_lastbad != 0) begin
        n_bad++; $display("FAIL dir%0d_last_align: got %0d misaligned cycles expected 0", t, mon_lastbad);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v[3];
    logic [1:0]   m[3];
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      v[i] = W'($urandom); m[i] = 2'($urandom);
      send_word(v[i], m[i], 0);
    end
    idle(3);
    n_vec++;
    if (mon_words.size() != 3 || mon_vcyc.size() != 3 * W) begin
      n_bad++; $display("FAIL b2b_count: got %0d words %0d bits expected 3 %0d", mon_words.size(), mon_vcyc.size(), 3 * W);
    end else begin
      n_vec++;
      if (mon_vcyc[3*W-1] - mon_vcyc[0] != 3 * W - 1) begin
        n_bad++; $display("FAIL b2b_bubble: got span %0d expected %0d", mon_vcyc[3*W-1] - mon_vcyc[0], 3 * W - 1);
      end
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (mon_words[i] !== model_res(v[i], m[i]) || mon_ovf[i] !== model_ovf(v[i], m[i])) begin
          n_bad++; $display("FAIL b2b_word%0d: got %h/%b expected %h/%b", i, mon_words[i], mon_ovf[i], model_res(v[i], m[i]), model_ovf(v[i], m[i]));
        end
      end
    end
  endtask

  task automatic test_gaps();
    int bad_gap;
    clear_mon();
    send_word(8'h01, 2'b01, 1);
    idle(3);
    bad_gap = 0;
    for (int i = 1; i < mon_vcyc.size(); i++) if (mon_vcyc[i] - mon_vcyc[i-1] != 2) bad_gap++;
    n_vec++;
    if (mon_vcyc.size() != W || bad_gap != 0) begin
      n_bad++; $display("FAIL gap_valid: got %0d bits %0d bad spacings expected %0d 0", mon_vcyc.size(), bad_gap, W);
    end
    n_vec++;
    if (mon_words.size() != 1 || mon_words[0] !== 8'hFF || mon_ovf[0] !== 1'b0) begin
      n_bad++; $display("FAIL gap_word: got %0d words first %h expected 1 word ff ovf 0", mon_words.size(), (mon_words.size() > 0) ? mon_words[0] : 8'h00);
    end
  endtask

  task automatic test_frame_err();
    logic [W-1:0] a, b, ser, exp;
    a = W'($urandom); b = W'($urandom);
    clear_mon();
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, a[i], 2'b01);
    send_word(b, 2'b10, 0);
    idle(3);
    exp = model_res(b, 2'b10);
    n_vec++;
    if (mon_ferr != 1) begin
      n_bad++; $display("FAIL ferr_pulse: got %0d pulses expected 1", mon_ferr);
    end
    n_vec++;
    if (mon_words.size() != 1 || mon_bits.size() != 4 + W) begin
      n_bad++; $display("FAIL ferr_count: got %0d words %0d bits expected 1 %0d", mon_words.size(), mon_bits.size(), 4 + W);
    end else begin
      for (int k = 0; k < W; k++) ser[k] = mon_bits[4 + k];
      n_vec++;
      if (mon_words[0] !== exp || ser !== exp) begin
        n_bad++; $display("FAIL ferr_wordB: got %h serial %h expected %h", mon_words[0], ser, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] v;
    send_word(8'hA5, 2'b00, 0);
    idle(2);
    n_vec++;
    if (bus.word_out !== 8'hA5) begin
      n_bad++; $display("FAIL pre_reset_word: got %h expected a5", bus.word_out);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b1, 2'b01);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.out_bit, bus.out_last, bus.word_out, bus.word_valid, bus.ovf, bus.frame_err} !== '0) begin
      n_bad++; $display("FAIL async_reset: got ov=%b wo=%h expected all zero", bus.out_valid, bus.word_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    clear_mon();
    v = W'($urandom);
    send_word(v, 2'b01, 0);
    idle(3);
    n_vec++;
    if (mon_words.size() != 1 || mon_ferr != 0 || mon_words[0] !== model_res(v, 2'b01)) begin
      n_bad++; $display("FAIL post_reset_word: got %0d words ferr %0d first %h expected 1 0 %h", mon_words.size(), mon_ferr, (mon_words.size() > 0) ? mon_words[0] : 8'h00, model_res(v, 2'b01));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ev[$];
    logic [1:0]   em[$];
    logic [W-1:0] v;
    logic [1:0]   m;
    clear_mon();
    for (int i = 0; i < 40; i++) begin
      v = W'($urandom); m = 2'($urandom);
      if ($urandom_range(0, 7) == 0) v = {1'b1, {(W-1){1'b0}}};
      ev.push_back(v); em.push_back(m);
      send_word(v, m, 2);
    end
    idle(4);
    n_vec++;
    if (mon_words.size() != 40 || mon_lastbad != 0 || mon_ferr != 0) begin
      n_bad++; $display("FAIL rand_count: got %0d words %0d misaligned %0d ferr expected 40 0 0", mon_words.size(), mon_lastbad, mon_ferr);
    end else begin
      for (int i = 0; i < 40; i++) begin
        n_vec++;
        if (mon_words[i] !== model_res(ev[i], em[i]) || mon_ovf[i] !== model_ovf(ev[i], em[i])) begin
          n_bad++; $display("FAIL rand_word%0d: in %h mode %0d got %h/%b expected %h/%b", i, ev[i], em[i], mon_words[i], mon_ovf[i], model_res(ev[i], em[i]), model_ovf(ev[i], em[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_gaps();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
